eth_rx_pack: RTL
================

Name: eth_rx_pack

Overview:
- Receive-side front end of the MAC, clocked by the PHY receive clock.
- Strips preamble/SFD from the 8-bit GMII/MII receive stream.
- Packs frame bytes into 32-bit words and writes them into the 512x32 receive RAM (active-low CEB/WEB port).
- Checks CRC-32, length and rx_er, then reports a frame descriptor to the register/DMA side and holds the buffer until it is released.

Parameters:
- ADR_WIDTH, 9, receive RAM word address width.
- DATA_WIDTH, 32, RAM word width; fixed at 4 bytes.
- MIN_FRAME, 64, minimum legal byte count (DA through FCS inclusive).

Ports:
- clk_i  in  1  receive clock (PHY rx_clk).
- reset_i  in  1  asynchronous active-high reset.
- rx_en_i  in  1  receiver enable from control register.
- rx_dv_i  in  1  GMII receive data valid.
- rx_er_i  in  1  GMII receive error.
- rx_d_i  in  8  GMII receive data.
- ram_a_o  out  ADR_WIDTH  RAM word address.
- ram_d_o  out  32  RAM write data.
- ram_ceb_o  out  1  RAM chip enable, active low.
- ram_web_o  out  1  RAM write enable, active low.
- frame_done_o  out  1  one-cycle pulse, descriptor valid.
- frame_len_o  out  12  byte count DA..FCS; held until frame_ack_i.
- frame_err_o  out  4  {runt, overflow, rx_er, crc_bad}; held until frame_ack_i.
- frame_ack_i  in  1  buffer released by consumer.
- busy_o  out  1  high in any state except IDLE.
- drop_cnt_o  out  16  saturating count of frames not accepted.

Behaviour:
- Reset values:
  - State IDLE.
  - ram_ceb_o=1, ram_web_o=1, ram_a_o=0, ram_d_o=0.
  - frame_done_o=0, frame_len_o=0, frame_err_o=0, busy_o=0, drop_cnt_o=0.
  - CRC register 0xFFFFFFFF.
- All outputs are registered.
- States: IDLE, PREAMBLE, DATA, FLUSH, HOLD, DROP.
- IDLE:
  - Waits for rx_dv_i=1 while rx_dv was 0 on the previous cycle (start of frame).
  - If rx_en_i=0: increment drop_cnt_o, go to DROP.
  - Else byte 0x55 -> PREAMBLE; byte 0xD5 -> DATA (short preamble accepted); any other byte -> DROP.
- PREAMBLE:
  - 0x55 -> stay; 0xD5 -> DATA; any other byte -> DROP.
  - rx_dv_i=0 -> IDLE; no descriptor is produced.
- DATA:
  - Each cycle with rx_dv_i=1 accepts one byte.
  - Byte lane: byte_cnt[1:0] selects lane; lane 0 is bits [7:0] (little-endian).
  - CRC update: reflected poly 0xEDB88320.
  - byte_cnt increments by 1.
  - The cycle after the 4th lane is filled: ram_ceb_o=0, ram_web_o=0, ram_a_o=word index, ram_d_o=packed word; the strobe lasts exactly one cycle.
  - Word index starts at 0 for every frame.
  - rx_er_i=1 on any data cycle sets the rx_er flag.
  - Overflow:
    - A byte beyond 4*2^ADR_WIDTH (2048) sets the overflow flag.
    - No further writes occur; the address never wraps.
    - byte_cnt saturates at 4095.
  - rx_dv_i=0 -> FLUSH.
- FLUSH (1 cycle):
  - If byte_cnt%4 != 0 and no overflow, write the partial word with unused upper lanes zero.
  - Latch frame_len_o=byte_cnt and frame_err_o:
    - crc_bad = (CRC register != 0xDEBB20E3);
    - runt = (byte_cnt < MIN_FRAME).
  - Next state HOLD; frame_done_o=1 in the first HOLD cycle only.
- HOLD:
  - Descriptor is stable; rx data is ignored.
  - Any frame start seen in HOLD increments drop_cnt_o.
  - frame_ack_i=1: go to IDLE if rx_dv_i=0, else DROP.
  - Reset the CRC register and byte_cnt on exit.
- DROP: wait for rx_dv_i=0, then go to IDLE.
- frame_ack_i outside HOLD is ignored.
- Reset mid-frame: returns to IDLE immediately. The frame in progress is not reported; its remaining bytes are treated as DROP only if rx_dv_i is still high at release.
- drop_cnt_o holds at 0xFFFF.
- Latency: last data byte sampled -> frame_done_o visible is 3 clk_i edges.

Test Plan:
- 7x0x55, 0xD5, then a 64-byte frame with valid FCS -> 16 writes at addresses 0..15; word0 = {B3,B2,B1,B0}; frame_len_o=64; frame_err_o=0; one frame_done_o pulse; busy_o=1 until frame_ack_i.
- 66-byte valid frame -> 17 writes; address 16 carries {16'h0, B65, B64}; frame_len_o=66; frame_err_o=0.
- 64-byte frame with last FCS byte inverted -> frame_err_o=4'b0001.
- rx_er_i pulsed on data byte 10 -> frame_err_o=4'b0010.
- 40-byte valid frame -> frame_err_o[3]=1, frame_len_o=40.
- 2100-byte frame -> exactly 512 writes at addresses 0..511, none after; frame_err_o[2]=1; frame_len_o=2100.
- Second frame during HOLD -> no RAM writes, drop_cnt_o=1; ack mid-frame -> DROP, then next frame accepted normally.
- rx_en_i=0 and a frame arrives -> drop_cnt_o increments, ram_ceb_o stays 1.
- reset_i asserted in DATA -> all outputs at reset values in the same cycle.

Source files
------------

// File: rtl/eth_rx_pack.sv
// ---------------------------------------------------------------------------
// eth_rx_pack
//   Receive-side MAC front end in the PHY rx_clk domain. Strips the
//   preamble/SFD from the GMII byte stream, packs frame bytes little-endian
//   into 32-bit words and writes them into the receive RAM. It checks
//   CRC-32, length and rx_er, then presents a frame descriptor that stays
//   held until the consumer releases the buffer.
//
// Ports
//   clk_i, reset_i        receive clock, asynchronous active-high reset
//   rx_en_i               receiver enable (frames are dropped when low)
//   rx_dv_i/rx_er_i/rx_d_i GMII receive data valid / error / data byte
//   ram_a_o/ram_d_o       RAM word address / write data
//   ram_ceb_o/ram_web_o   RAM chip enable / write enable, both active low
//   frame_done_o          one-cycle pulse: descriptor valid
//   frame_len_o           byte count DA..FCS
//   frame_err_o           {runt, overflow, rx_er, crc_bad}
//   frame_ack_i           consumer releases the buffer (HOLD only)
//   busy_o                high whenever the FSM is not IDLE
//   drop_cnt_o            saturating count of frames not accepted
//
// Handshake: frame_done_o pulses once when the descriptor becomes valid;
// frame_len_o/frame_err_o are then stable until frame_ack_i is sampled high
// in HOLD. frame_ack_i is ignored in every other state.
// ---------------------------------------------------------------------------
module eth_rx_pack #(
    parameter int ADR_WIDTH  = 9,
    parameter int DATA_WIDTH = 32,
    parameter int MIN_FRAME  = 64
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  rx_en_i,
    input  logic                  rx_dv_i,
    input  logic                  rx_er_i,
    input  logic [7:0]            rx_d_i,
    output logic [ADR_WIDTH-1:0]  ram_a_o,
    output logic [DATA_WIDTH-1:0] ram_d_o,
    output logic                  ram_ceb_o,
    output logic                  ram_web_o,
    output logic                  frame_done_o,
    output logic [11:0]           frame_len_o,
    output logic [3:0]            frame_err_o,
    input  logic                  frame_ack_i,
    output logic                  busy_o,
    output logic [15:0]           drop_cnt_o
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_PREAMBLE = 3'd1;
    localparam logic [2:0] S_DATA     = 3'd2;
    localparam logic [2:0] S_FLUSH    = 3'd3;
    localparam logic [2:0] S_HOLD     = 3'd4;
    localparam logic [2:0] S_DROP     = 3'd5;

    localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
    // Bytes that fit in the receive RAM.
    localparam logic [12:0] CAP_BYTES   = 13'(4 << ADR_WIDTH);

    logic [2:0]  state;
    logic [2:0]  state_nxt;
    logic        dv_q;
    logic        sof;
    logic        in_cap;
    logic        inc_drop;
    logic [11:0] byte_cnt;
    logic [31:0] crc;
    logic [23:0] lane_buf;   // lanes 0..2 of the word being assembled
    logic        ovf_flag;
    logic        er_flag;

    // Reflected CRC-32 update for one byte, LSB first, no final inversion.
    function automatic logic [31:0] crc32_byte(input logic [31:0] c,
                                               input logic [7:0]  d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
        end
        return r;
    endfunction

    assign sof      = rx_dv_i & ~dv_q;
    assign in_cap   = ({1'b0, byte_cnt} < CAP_BYTES);
    assign inc_drop = sof & (((state == S_IDLE) & ~rx_en_i) | (state == S_HOLD));

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                // dv already high without a rising edge means we joined a
                // frame midway (e.g. reset released mid-frame): discard it.
                if (rx_dv_i) begin
                    if (dv_q || !rx_en_i)    state_nxt = S_DROP;
                    else if (rx_d_i == 8'h55) state_nxt = S_PREAMBLE;
                    else if (rx_d_i == 8'hD5) state_nxt = S_DATA;
                    else                      state_nxt = S_DROP;
                end
            end
            S_PREAMBLE: begin
                if (!rx_dv_i)              state_nxt = S_IDLE;
                else if (rx_d_i == 8'hD5)  state_nxt = S_DATA;
                else if (rx_d_i != 8'h55)  state_nxt = S_DROP;
            end
            S_DATA:  if (!rx_dv_i) state_nxt = S_FLUSH;
            S_FLUSH: state_nxt = S_HOLD;
            S_HOLD:  if (frame_ack_i) state_nxt = rx_dv_i ? S_DROP : S_IDLE;
            S_DROP:  if (!rx_dv_i) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state        <= S_IDLE;
            // Treat dv as already high so a frame still running at reset
            // release is not mistaken for a new start.
            dv_q         <= 1'b1;
            byte_cnt     <= '0;
            crc          <= 32'hFFFFFFFF;
            lane_buf     <= '0;
            ovf_flag     <= 1'b0;
            er_flag      <= 1'b0;
            ram_a_o      <= '0;
            ram_d_o      <= '0;
            ram_ceb_o    <= 1'b1;
            ram_web_o    <= 1'b1;
            frame_done_o <= 1'b0;
            frame_len_o  <= '0;
            frame_err_o  <= '0;
            busy_o       <= 1'b0;
            drop_cnt_o   <= '0;
        end else begin
            state        <= state_nxt;
            busy_o       <= (state_nxt != S_IDLE);
            dv_q         <= rx_dv_i;
            ram_ceb_o    <= 1'b1;
            ram_web_o    <= 1'b1;
            frame_done_o <= 1'b0;

            if (inc_drop && (drop_cnt_o != 16'hFFFF)) begin
                drop_cnt_o <= drop_cnt_o + 16'd1;
            end

            case (state)
                S_DATA: begin
                    if (rx_dv_i) begin
                        crc <= crc32_byte(crc, rx_d_i);
                        if (byte_cnt != 12'hFFF) byte_cnt <= byte_cnt + 12'd1;
                        if (rx_er_i) er_flag <= 1'b1;
                        if (!in_cap) begin
                            ovf_flag <= 1'b1;
                        end else begin
                            case (byte_cnt[1:0])
                                // Lane 0 clears the upper lanes so a partial
                                // tail word is zero-padded.
                                2'd0: lane_buf        <= {16'h0, rx_d_i};
                                2'd1: lane_buf[15:8]  <= rx_d_i;
                                2'd2: lane_buf[23:16] <= rx_d_i;
                                default: begin
                                    ram_ceb_o <= 1'b0;
                                    ram_web_o <= 1'b0;
                                    ram_a_o   <= byte_cnt[ADR_WIDTH+1:2];
                                    ram_d_o   <= {rx_d_i, lane_buf};
                                end
                            endcase
                        end
                    end
                end
                S_FLUSH: begin
                    if ((byte_cnt[1:0] != 2'd0) && !ovf_flag) begin
                        ram_ceb_o <= 1'b0;
                        ram_web_o <= 1'b0;
                        ram_a_o   <= byte_cnt[ADR_WIDTH+1:2];
                        ram_d_o   <= {8'h0, lane_buf};
                    end
                    frame_len_o  <= byte_cnt;
                    frame_err_o  <= {(byte_cnt < 12'(MIN_FRAME)), ovf_flag,
                                     er_flag, (crc != CRC_RESIDUE)};
                    frame_done_o <= 1'b1;
                end
                S_HOLD: begin
                    if (frame_ack_i) begin
                        crc      <= 32'hFFFFFFFF;
                        byte_cnt <= '0;
                        ovf_flag <= 1'b0;
                        er_flag  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
